// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg : default 640x480@60 raster constants and timing helpers
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_COORD_W   = 10;

  typedef logic [DEF_COORD_W-1:0] coord_t;

  function automatic int calc_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_generator_if.sv
// ----------------------------------------------------------------------------
// vga_timing_generator_if : raster timing bundle from generator to consumers
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vga_timing_generator_if #(
  parameter int COORD_W = vga_timing_pkg::DEF_COORD_W
);
  logic               hsync;
  logic               vsync;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               video_active;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;

  modport master (
    output hsync, vsync, pixel_x, pixel_y,
    output video_active, line_start, frame_start, vblank_start
  );

  modport slave (
    input hsync, vsync, pixel_x, pixel_y,
    input video_active, line_start, frame_start, vblank_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter : wrapping position counter for one raster axis with
//                    registered position/sync and a next-cycle active flag
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE         = DEF_H_VISIBLE,
  parameter int FRONT           = DEF_H_FRONT,
  parameter int SYNC            = DEF_H_SYNC,
  parameter int BACK            = DEF_H_BACK,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int COORD_W         = DEF_COORD_W
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               i_advance,
  output logic                    o_wrap,
  output logic      [COORD_W-1:0] o_pos,
  output logic                    o_sync,
  output logic                    o_active_d
);

  localparam int                 c_total     = calc_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [COORD_W-1:0] c_last      = COORD_W'(c_total - 1);
  localparam logic [COORD_W-1:0] c_vis       = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] c_sync_lo   = COORD_W'(VISIBLE + FRONT);
  localparam logic [COORD_W-1:0] c_sync_hi   = COORD_W'(VISIBLE + FRONT + SYNC);
  localparam logic               c_sync_idle = (SYNC_ACTIVE_LOW != 0);

  if (FRONT <= 0 || SYNC <= 0 || BACK <= 0) begin : g_bad_segment
    $fatal(1, "vga_axis_counter: porch and sync lengths must be positive");
  end
  if (c_total > (1 << COORD_W)) begin : g_bad_width
    $fatal(1, "vga_axis_counter: axis total does not fit in COORD_W bits");
  end

  logic [COORD_W-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0] pos_q;
  logic               sync_q, sync_d;

  // cnt_q starts on the last position so the first edge lands on 0
  always_comb begin
    o_wrap     = i_advance && (cnt_q == c_last);
    cnt_d      = cnt_q;
    if (i_advance) begin
      cnt_d = o_wrap ? '0 : cnt_q + COORD_W'(1);
    end
    sync_d     = ((cnt_d >= c_sync_lo) && (cnt_d < c_sync_hi)) ? ~c_sync_idle : c_sync_idle;
    o_active_d = (cnt_d < c_vis);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= c_last;
      pos_q  <= '0;
      sync_q <= c_sync_idle;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign o_pos  = pos_q;
  assign o_sync = sync_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_generator.sv
// ----------------------------------------------------------------------------
// vga_timing_generator : VGA raster timing (syncs, coordinates, strobes)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int COORD_W         = DEF_COORD_W
) (
  input wire logic clk,
  input wire logic rst_n,
  vga_timing_generator_if.master vga
);

  logic               h_wrap, v_wrap;
  logic               h_sync, v_sync;
  logic               h_active_d, v_active_d;
  logic [COORD_W-1:0] h_pos, v_pos;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW), .COORD_W(COORD_W)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .i_advance(1'b1),
    .o_wrap(h_wrap), .o_pos(h_pos), .o_sync(h_sync), .o_active_d(h_active_d)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW), .COORD_W(COORD_W)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .i_advance(h_wrap),
    .o_wrap(v_wrap), .o_pos(v_pos), .o_sync(v_sync), .o_active_d(v_active_d)
  );

  logic v_active_q;
  logic video_active_q, video_active_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic vblank_start_q, vblank_start_d;

  // A vertical wrap only happens on a horizontal wrap, so it marks (0,0) next
  always_comb begin
    video_active_d = h_active_d && v_active_d;
    line_start_d   = h_wrap;
    frame_start_d  = v_wrap;
    vblank_start_d = v_active_q && !v_active_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_active_q     <= 1'b0;
      video_active_q <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      v_active_q     <= v_active_d;
      video_active_q <= video_active_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign vga.hsync        = h_sync;
  assign vga.vsync        = v_sync;
  assign vga.pixel_x      = h_pos;
  assign vga.pixel_y      = v_pos;
  assign vga.video_active = video_active_q;
  assign vga.line_start   = line_start_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_generator : directed checks on a default 640x480 instance and
//                           a tiny active-high-sync instance (14x7 raster)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_timing_generator_if #(.COORD_W(10)) va ();
  vga_timing_generator_if #(.COORD_W(4))  vb ();

  vga_timing_generator u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .vga(va)
  );

  vga_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(0), .COORD_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .vga(vb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt, bad_px, bad_py, n_hs, first_hs, last_hs, n_act, n_line, n_frame, n_vbl;
    int bad_hs, bad_vs, bad_act, bad_line, bad_frame, n_vs, vs_x, vs_y, vbl_x, vbl_y;
    int last_x, last_y, max_x, max_y, h, v;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (5) @(negedge clk);

    // Reset values while held
    check("a_rst_hsync",  32'(va.hsync), 1);
    check("a_rst_vsync",  32'(va.vsync), 1);
    check("a_rst_px",     32'(va.pixel_x), 0);
    check("a_rst_py",     32'(va.pixel_y), 0);
    check("a_rst_active", 32'(va.video_active), 0);
    check("a_rst_line",   32'(va.line_start), 0);
    check("a_rst_frame",  32'(va.frame_start), 0);
    check("a_rst_vblank", 32'(va.vblank_start), 0);
    check("b_rst_hsync",  32'(vb.hsync), 0);
    check("b_rst_vsync",  32'(vb.vsync), 0);
    check("b_rst_px",     32'(vb.pixel_x), 0);
    check("b_rst_active", 32'(vb.video_active), 0);

    // Default instance: first edge after release
    rst_a_n = 1'b1;
    @(negedge clk);
    check("a_first_px",     32'(va.pixel_x), 0);
    check("a_first_py",     32'(va.pixel_y), 0);
    check("a_first_frame",  32'(va.frame_start), 1);
    check("a_first_line",   32'(va.line_start), 1);
    check("a_first_active", 32'(va.video_active), 1);
    check("a_first_hsync",  32'(va.hsync), 1);
    check("a_first_vsync",  32'(va.vsync), 1);
    check("a_first_vblank", 32'(va.vblank_start), 0);

    // One full line of the default raster
    bad_px = 0; bad_py = 0; n_hs = 0; first_hs = -1; last_hs = -1;
    n_act = 0; n_line = 0; n_frame = 0; n_vbl = 0;
    for (int i = 0; i < 800; i++) begin
      if (32'(va.pixel_x) !== 32'(i)) bad_px++;
      if (va.pixel_y !== 10'd0) bad_py++;
      if (va.hsync === 1'b0) begin
        if (first_hs < 0) first_hs = int'(va.pixel_x);
        last_hs = int'(va.pixel_x);
        n_hs++;
      end
      if (va.video_active === 1'b1) n_act++;
      if (va.line_start === 1'b1) n_line++;
      if (va.frame_start === 1'b1) n_frame++;
      if (va.vblank_start === 1'b1) n_vbl++;
      @(negedge clk);
    end
    check("a_line_px_seq",   bad_px, 0);
    check("a_line_py_hold",  bad_py, 0);
    check("a_hsync_width",   n_hs, 96);
    check("a_hsync_first",   first_hs, 656);
    check("a_hsync_last",    last_hs, 751);
    check("a_active_count",  n_act, 640);
    check("a_line_pulses",   n_line, 1);
    check("a_frame_pulses",  n_frame, 1);
    check("a_vblank_pulses", n_vbl, 0);
    check("a_line1_px",      32'(va.pixel_x), 0);
    check("a_line1_py",      32'(va.pixel_y), 1);
    check("a_line1_strobe",  32'(va.line_start), 1);
    check("a_line1_frame",   32'(va.frame_start), 0);

    // Asynchronous reset part-way through a line
    repeat (300) @(negedge clk);
    check("a_pre_rst_px", 32'(va.pixel_x), 300);
    @(posedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    check("a_async_px",     32'(va.pixel_x), 0);
    check("a_async_py",     32'(va.pixel_y), 0);
    check("a_async_hsync",  32'(va.hsync), 1);
    check("a_async_active", 32'(va.video_active), 0);
    repeat (3) @(negedge clk);
    check("a_held_px",    32'(va.pixel_x), 0);
    check("a_held_line",  32'(va.line_start), 0);
    rst_a_n = 1'b1;
    @(negedge clk);
    check("a_restart_px",    32'(va.pixel_x), 0);
    check("a_restart_py",    32'(va.pixel_y), 0);
    check("a_restart_frame", 32'(va.frame_start), 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (va.line_start !== 1'b1 && cnt < 2000);
    check("a_line_period", cnt, 800);
    check("a_period_py",   32'(va.pixel_y), 1);

    // Small active-high instance: whole frame against the raster equations
    rst_b_n = 1'b1;
    @(negedge clk);
    check("b_first_px",    32'(vb.pixel_x), 0);
    check("b_first_frame", 32'(vb.frame_start), 1);
    check("b_first_hsync", 32'(vb.hsync), 0);
    bad_px = 0; bad_py = 0; bad_hs = 0; bad_vs = 0; bad_act = 0; bad_line = 0; bad_frame = 0;
    n_hs = 0; n_vs = 0; vs_x = -1; vs_y = -1; n_vbl = 0; vbl_x = -1; vbl_y = -1;
    max_x = 0; max_y = 0; last_x = -1; last_y = -1;
    for (int i = 0; i < 98; i++) begin
      h = i % 14;
      v = i / 14;
      if (32'(vb.pixel_x) !== 32'(h)) bad_px++;
      if (32'(vb.pixel_y) !== 32'(v)) bad_py++;
      if (vb.hsync !== ((h >= 10 && h <= 12) ? 1'b1 : 1'b0)) bad_hs++;
      if (vb.vsync !== ((v == 5) ? 1'b1 : 1'b0)) bad_vs++;
      if (vb.video_active !== ((h < 8 && v < 4) ? 1'b1 : 1'b0)) bad_act++;
      if (vb.line_start !== ((h == 0) ? 1'b1 : 1'b0)) bad_line++;
      if (vb.frame_start !== ((i == 0) ? 1'b1 : 1'b0)) bad_frame++;
      if (vb.hsync === 1'b1) n_hs++;
      if (vb.vsync === 1'b1) begin
        if (vs_x < 0) begin vs_x = int'(vb.pixel_x); vs_y = int'(vb.pixel_y); end
        n_vs++;
      end
      if (vb.vblank_start === 1'b1) begin
        n_vbl++;
        vbl_x = int'(vb.pixel_x);
        vbl_y = int'(vb.pixel_y);
      end
      if (int'(vb.pixel_x) > max_x) max_x = int'(vb.pixel_x);
      if (int'(vb.pixel_y) > max_y) max_y = int'(vb.pixel_y);
      last_x = int'(vb.pixel_x);
      last_y = int'(vb.pixel_y);
      @(negedge clk);
    end
    check("b_px_seq",      bad_px, 0);
    check("b_py_seq",      bad_py, 0);
    check("b_hsync_shape", bad_hs, 0);
    check("b_vsync_shape", bad_vs, 0);
    check("b_active",      bad_act, 0);
    check("b_line_start",  bad_line, 0);
    check("b_frame_start", bad_frame, 0);
    check("b_hsync_count", n_hs, 21);
    check("b_vsync_count", n_vs, 14);
    check("b_vsync_x",     vs_x, 0);
    check("b_vsync_y",     vs_y, 5);
    check("b_vblank_cnt",  n_vbl, 1);
    check("b_vblank_x",    vbl_x, 0);
    check("b_vblank_y",    vbl_y, 4);
    check("b_corner_x",    last_x, 13);
    check("b_corner_y",    last_y, 6);
    check("b_max_x",       max_x, 13);
    check("b_max_y",       max_y, 6);
    check("b_wrap_px",     32'(vb.pixel_x), 0);
    check("b_wrap_py",     32'(vb.pixel_y), 0);
    check("b_wrap_frame",  32'(vb.frame_start), 1);
    check("b_wrap_line",   32'(vb.line_start), 1);

    // Mid-frame reset on the small instance at (5,3)
    repeat (47) @(negedge clk);
    check("b_pre_rst_px", 32'(vb.pixel_x), 5);
    check("b_pre_rst_py", 32'(vb.pixel_y), 3);
    @(posedge clk);
    #2 rst_b_n = 1'b0;
    #1;
    check("b_async_px",    32'(vb.pixel_x), 0);
    check("b_async_py",    32'(vb.pixel_y), 0);
    check("b_async_hsync", 32'(vb.hsync), 0);
    check("b_async_line",  32'(vb.line_start), 0);
    repeat (3) @(negedge clk);
    check("b_held_frame", 32'(vb.frame_start), 0);
    rst_b_n = 1'b1;
    @(negedge clk);
    check("b_restart_px",    32'(vb.pixel_x), 0);
    check("b_restart_py",    32'(vb.pixel_y), 0);
    check("b_restart_frame", 32'(vb.frame_start), 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (vb.frame_start !== 1'b1 && cnt < 300);
    check("b_frame_period", cnt, 98);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
